// File: rtl/bd_funnel_arbiter_pkg.sv
// Shared BD word definitions: unencoded word channel payload, leaf length table
// and the arbiter state type used by bd_funnel_arbiter.
package bd_funnel_arbiter_pkg;

    localparam int LEAF_CODE_W = 5;
    localparam int PAYLOAD_W   = 21;
    localparam int NUM_LEAVES  = 32;

    typedef struct packed {
        logic [LEAF_CODE_W-1:0] leaf_code;
        logic [PAYLOAD_W-1:0]   payload;
    } unencoded_bd_word_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } funnel_state_t;

    // Packet length minus one per leaf code; entry 31 is the leftmost pair.
    // Codes 0..15 cycle 1,2,3,4 words, codes 16..31 cycle 4,3,2,1 words.
    localparam logic [NUM_LEAVES-1:0][1:0] LEAF_WORDS = 64'h1B1B1B1B_E4E4E4E4;

    function automatic logic [1:0] leaf_words_m1(input logic [LEAF_CODE_W-1:0] code);
        return LEAF_WORDS[code];
    endfunction

endpackage

// File: rtl/bd_funnel_arbiter_picker.sv
// Round-robin picker: grants the first requester after ptr (wrapping), purely
// combinational, one-hot grant plus its index.
module bd_funnel_arbiter_picker #(
    parameter int NUM_SRC = 4,
    localparam int IDX_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_SRC-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);

    logic [IDX_W-1:0] cand;

    // Walk ptr+1, ptr+2, ... so the source at ptr itself is visited last.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand = IDX_W'((int'(ptr) + k) % NUM_SRC);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/bd_funnel_arbiter.sv
// Funnels NUM_SRC BD word sources into one registered output, keeping packets
// contiguous. Define BD_FUNNEL_ARB_PRIO0_EN to give source 0 priority when idle.
module bd_funnel_arbiter
    import bd_funnel_arbiter_pkg::*;
#(
    parameter int NUM_SRC = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  unencoded_bd_word_t [NUM_SRC-1:0] words_in,
    input  logic [NUM_SRC-1:0]               words_in_v,
    output logic [NUM_SRC-1:0]               words_in_a,
    output unencoded_bd_word_t               words_out,
    output logic                             words_out_v,
    input  logic                             words_out_a
);

    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    funnel_state_t      state;
    logic [1:0]         remaining;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   lock_idx;

    logic [NUM_SRC-1:0] pick_req;
    logic [NUM_SRC-1:0] pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_found;
    logic               prio0_hit;

    logic [NUM_SRC-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               can_load;
    logic               accept;
    unencoded_bd_word_t sel_word;
    logic [1:0]         sel_len_m1;

`ifdef BD_FUNNEL_ARB_PRIO0_EN
    // Source 0 bypasses the rotation, so the picker only rotates over 1..N-1.
    assign prio0_hit = words_in_v[0];
    assign pick_req  = {words_in_v[NUM_SRC-1:1], 1'b0};
`else
    assign prio0_hit = 1'b0;
    assign pick_req  = words_in_v;
`endif

    bd_funnel_arbiter_picker #(.NUM_SRC(NUM_SRC)) u_picker (
        .req   (pick_req),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        if (state == LOCKED) begin
            if (words_in_v[lock_idx]) begin
                grant[lock_idx] = 1'b1;
                grant_idx       = lock_idx;
            end
        end else if (prio0_hit) begin
            grant[0]  = 1'b1;
            grant_idx = '0;
        end else if (pick_found) begin
            grant     = pick_grant;
            grant_idx = pick_idx;
        end
    end

    // A word may enter whenever the output slot is empty or leaving this cycle.
    assign can_load   = !words_out_v || words_out_a;
    assign words_in_a = can_load ? grant : '0;
    assign accept     = (|grant) && can_load;
    assign sel_word   = words_in[grant_idx];
    assign sel_len_m1 = leaf_words_m1(sel_word.leaf_code);

    always_ff @(posedge clk) begin
        if (reset) begin
            words_out   <= '0;
            words_out_v <= 1'b0;
            state       <= IDLE;
            remaining   <= 2'd0;
            rr_ptr      <= IDX_W'(NUM_SRC - 1);
            lock_idx    <= '0;
        end else begin
            if (accept) begin
                words_out   <= sel_word;
                words_out_v <= 1'b1;
            end else if (words_out_a) begin
                words_out_v <= 1'b0;
            end

            // Only a packet's last word moves the rotation pointer.
            if (accept) begin
                case (state)
                    IDLE: begin
                        if (sel_len_m1 != 2'd0) begin
                            state     <= LOCKED;
                            remaining <= sel_len_m1;
                            lock_idx  <= grant_idx;
                        end else begin
                            rr_ptr <= grant_idx;
                        end
                    end
                    LOCKED: begin
                        if (remaining == 2'd1) begin
                            state     <= IDLE;
                            remaining <= 2'd0;
                            rr_ptr    <= lock_idx;
                        end else begin
                            remaining <= remaining - 2'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bd_funnel_arbiter.sv
// Bench for bd_funnel_arbiter: directed scenarios followed by random traffic,
// all checked cycle by cycle against a queue-based packet model.
module tb_bd_funnel_arbiter;
    import bd_funnel_arbiter_pkg::*;

    localparam int N = 4;

    typedef logic [25:0] word_t;
    typedef word_t word_q_t [$];

    logic               clk = 1'b0;
    logic               reset;
    unencoded_bd_word_t [N-1:0] words_in;
    logic [N-1:0]       words_in_v;
    logic [N-1:0]       words_in_a;
    unencoded_bd_word_t words_out;
    logic               words_out_v;
    logic               words_out_a;

    bd_funnel_arbiter #(.NUM_SRC(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .words_in    (words_in),
        .words_in_v  (words_in_v),
        .words_in_a  (words_in_a),
        .words_out   (words_out),
        .words_out_v (words_out_v),
        .words_out_a (words_out_a)
    );

    always #5 clk = ~clk;

    int      checks = 0;
    int      errors = 0;
    word_q_t src_q [N];
    word_t   out_log [$];
    int      vcount;
    logic [N-1:0] last_a;

    // Reference model: which source owns the current packet (-1 = none),
    // how many of its words are still due, and who finished a packet last.
    int      m_owner;
    int      m_left;
    int      m_last;
    int      m_grant;
    logic    m_out_v;
    word_t   m_out;

    function automatic int leaf_len(input int code);
        return (code < 16) ? (code % 4) + 1 : 4 - (code % 4);
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_left  = 0;
        m_last  = N - 1;
        m_grant = -1;
        m_out_v = 1'b0;
        m_out   = '0;
    endtask

    task automatic flush_sources();
        for (int i = 0; i < N; i++) src_q[i].delete();
        out_log.delete();
    endtask

    task automatic push_word(input int s, input logic [4:0] leaf, input logic [20:0] payload);
        src_q[s].push_back({leaf, payload});
    endtask

    task automatic push_packet(input int s, input int code, input int tag);
        logic [4:0] leaf;
        logic [2:0] sid;
        sid = 3'(s);
        for (int k = 0; k < leaf_len(code); k++) begin
            leaf = (k == 0) ? 5'(code) : 5'($urandom_range(0, 31));
            push_word(s, leaf, {sid, 18'(tag * 4 + k)});
        end
    endtask

    // Decide which source should win this cycle from the visible requests.
    task automatic predict(input logic sink_rdy);
        int g;
        g = -1;
        if (m_owner >= 0) begin
            if (words_in_v[m_owner]) g = m_owner;
        end else begin
`ifdef BD_FUNNEL_ARB_PRIO0_EN
            if (words_in_v[0]) g = 0;
            for (int k = 1; k <= N && g < 0; k++) begin
                int s;
                s = (m_last + k) % N;
                if (s != 0 && words_in_v[s]) g = s;
            end
`else
            for (int k = 1; k <= N && g < 0; k++) begin
                int s;
                s = (m_last + k) % N;
                if (words_in_v[s]) g = s;
            end
`endif
        end
        m_grant = (!m_out_v || sink_rdy) ? g : -1;
    endtask

    task automatic apply_stimulus(input logic [N-1:0] allow, input logic sink_rdy, input logic rst);
        word_t w;
        @(negedge clk);
        reset       = rst;
        words_out_a = sink_rdy;
        for (int i = 0; i < N; i++) begin
            words_in_v[i] = allow[i] && (src_q[i].size() > 0);
            words_in[i]   = words_in_v[i] ? src_q[i][0] : '0;
        end
        predict(sink_rdy);
        #1;
        check_output("grant_a", 32'(words_in_a), (m_grant >= 0) ? (32'd1 << m_grant) : 32'd0);
        check_output("out_v", 32'(words_out_v), 32'(m_out_v));
        check_output("out_word", 32'(words_out), 32'(m_out));
        last_a = words_in_a;
        if (words_out_v) vcount++;
        if (words_out_v && sink_rdy && !rst) out_log.push_back(words_out);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (m_grant >= 0) begin
                w = src_q[m_grant].pop_front();
                if (m_owner < 0) begin
                    if (leaf_len(int'(w[25:21])) > 1) begin
                        m_owner = m_grant;
                        m_left  = leaf_len(int'(w[25:21])) - 1;
                    end else begin
                        m_last = m_grant;
                    end
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_last  = m_owner;
                        m_owner = -1;
                    end
                end
                m_out   = w;
                m_out_v = 1'b1;
            end else if (sink_rdy) begin
                m_out_v = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        apply_stimulus('0, 1'b1, 1'b1);
        apply_stimulus('0, 1'b1, 1'b1);
        flush_sources();
    endtask

    initial begin
        int tag;
        int pending;
        int exp_src [$];

        reset       = 1'b1;
        words_in    = '0;
        words_in_v  = '0;
        words_out_a = 1'b1;
        repeat (2) @(posedge clk);
        model_reset();
        flush_sources();

        @(negedge clk);
        #1;
        check_output("reset_out_v", 32'(words_out_v), 32'd0);
        check_output("reset_out_word", 32'(words_out), 32'd0);
        check_output("reset_a", 32'(words_in_a), 32'd0);

        $display("[TB] single word from source 0");
        push_word(0, 5'd0, 21'h1ABCD);
        vcount = 0;
        repeat (5) apply_stimulus('1, 1'b1, 1'b0);
        check_output("single_v_cycles", 32'(vcount), 32'd1);
        check_output("single_count", 32'(out_log.size()), 32'd1);
        if (out_log.size() > 0) check_output("single_word", 32'(out_log[0]), {6'd0, 5'd0, 21'h1ABCD});

`ifndef BD_FUNNEL_ARB_PRIO0_EN
        $display("[TB] round robin over four sources");
        do_reset();
        for (int s = 0; s < N; s++)
            for (int t = 0; t < 3; t++) push_packet(s, 0, 16 + s * 4 + t);
        repeat (14) apply_stimulus('1, 1'b1, 1'b0);
        check_output("rr_count", 32'(out_log.size()), 32'd12);
        for (int k = 0; k < out_log.size(); k++)
            check_output($sformatf("rr_src%0d", k), 32'(out_log[k][20:18]), 32'(k % N));
`else
        $display("[TB] source 0 priority");
        do_reset();
        for (int t = 0; t < 3; t++) begin
            push_packet(0, 0, 40 + t);
            push_packet(1, 0, 50 + t);
        end
        repeat (4) apply_stimulus('1, 1'b1, 1'b0);
        check_output("prio_count", 32'(out_log.size()), 32'd3);
        for (int k = 0; k < out_log.size(); k++)
            check_output($sformatf("prio_src%0d", k), 32'(out_log[k][20:18]), 32'd0);
        do_reset();
        push_packet(1, 1, 60);
        apply_stimulus(4'b0010, 1'b1, 1'b0);
        push_packet(0, 0, 61);
        repeat (5) apply_stimulus('1, 1'b1, 1'b0);
        exp_src = '{1, 1, 0};
        check_output("prio_lock_count", 32'(out_log.size()), 32'd3);
        for (int k = 0; k < out_log.size() && k < 3; k++)
            check_output($sformatf("prio_lock_src%0d", k), 32'(out_log[k][20:18]), 32'(exp_src[k]));
`endif

        $display("[TB] packet lock with a stalled owner");
        do_reset();
        push_packet(1, 2, 70);
        push_packet(2, 0, 71);
        push_packet(2, 0, 72);
        apply_stimulus('1, 1'b1, 1'b0);
        repeat (2) apply_stimulus(4'b0100, 1'b1, 1'b0);
        repeat (6) apply_stimulus('1, 1'b1, 1'b0);
        exp_src = '{1, 1, 1, 2, 2};
        check_output("lock_count", 32'(out_log.size()), 32'd5);
        for (int k = 0; k < out_log.size() && k < 5; k++)
            check_output($sformatf("lock_src%0d", k), 32'(out_log[k][20:18]), 32'(exp_src[k]));

        $display("[TB] sink backpressure");
        do_reset();
        push_packet(0, 0, 80);
        push_packet(0, 0, 81);
        push_packet(1, 0, 82);
        apply_stimulus('1, 1'b1, 1'b0);
        for (int c = 0; c < 5; c++) begin
            apply_stimulus('1, 1'b0, 1'b0);
            check_output($sformatf("stall_a%0d", c), 32'(last_a), 32'd0);
        end
        repeat (5) apply_stimulus('1, 1'b1, 1'b0);
`ifdef BD_FUNNEL_ARB_PRIO0_EN
        exp_src = '{0, 0, 1};
`else
        exp_src = '{0, 1, 0};
`endif
        check_output("stall_count", 32'(out_log.size()), 32'd3);
        for (int k = 0; k < out_log.size() && k < 3; k++)
            check_output($sformatf("stall_src%0d", k), 32'(out_log[k][20:18]), 32'(exp_src[k]));

        $display("[TB] reset in the middle of a packet");
        do_reset();
        push_packet(3, 3, 90);
        apply_stimulus('1, 1'b1, 1'b0);
        apply_stimulus('1, 1'b1, 1'b0);
        apply_stimulus('1, 1'b1, 1'b1);
        flush_sources();
        apply_stimulus('1, 1'b1, 1'b0);
        check_output("midreset_out_v", 32'(words_out_v), 32'd0);
        for (int s = 0; s < N; s++) push_packet(s, 0, 100 + s);
        apply_stimulus('1, 1'b1, 1'b0);
        check_output("midreset_first_grant", 32'(last_a), 32'd1);
        repeat (6) apply_stimulus('1, 1'b1, 1'b0);

        $display("[TB] random traffic");
        do_reset();
        tag = 200;
        for (int c = 0; c < 600; c++) begin
            logic [N-1:0] allow;
            for (int s = 0; s < N; s++) begin
                if (src_q[s].size() < 6 && $urandom_range(0, 3) == 0) begin
                    push_packet(s, int'($urandom_range(0, 31)), tag);
                    tag++;
                end
                allow[s] = ($urandom_range(0, 3) != 0);
            end
            apply_stimulus(allow, $urandom_range(0, 3) != 0, 1'b0);
        end
        pending = 1;
        for (int c = 0; c < 400 && pending != 0; c++) begin
            apply_stimulus('1, 1'b1, 1'b0);
            pending = int'(m_out_v);
            for (int s = 0; s < N; s++) pending += src_q[s].size();
        end
        check_output("drain_pending", 32'(pending), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bd_funnel_arbiter.md
BD_FUNNEL_ARBITER -- requirements
Module: BDFunnelArbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4, meaning number of requesting word sources (2..8).
REQ-002 SHALL have port clk, input, 1 bit: single clock, all logic on posedge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port words_in[NUM_SRC], UnencodedBDWordChannel array, per source: leaf_code 5 bits, payload 21 bits, v in, a out.
REQ-005 SHALL have port words_out, UnencodedBDWordChannel: leaf_code 5 bits, payload 21 bits, v out, a in; feeds BDFunnelSerializer/BDFunnelEncoder.

Function
REQ-006 SHALL transfer a word on any channel exactly in a cycle where v && a is high at posedge clk.
REQ-007 SHALL assert words_in[i].a only for the granted source i, and only when the output register is empty or is being drained this cycle (words_out.v && words_out.a).
REQ-008 SHALL register each accepted word into a one-entry output register; words_out.v rises the cycle after acceptance (latency 1); sustained throughput 1 word/cycle.
REQ-009 SHALL hold words_out.leaf_code/payload stable and words_out.v high until words_out.a is seen.
REQ-010 SHALL treat a packet as LEAF_WORDS[leaf_code] consecutive words from one source; the first word's leaf_code selects length (1..4).
REQ-011 SHALL implement states IDLE and LOCKED plus a 2-bit remaining-word counter.
REQ-012 IDLE: grant = first source with v high, searching round-robin starting at rr_ptr+1 (mod NUM_SRC); on accept of a word with LEAF_WORDS > 1 go LOCKED with remaining = LEAF_WORDS-1, else stay IDLE.
REQ-013 LOCKED: grant stays on the locked source regardless of other v; each accept decrements remaining; accept at remaining==1 returns to IDLE.
REQ-014 SHALL update rr_ptr to the granted source index on acceptance of a packet's last word only.
REQ-015 SHALL, while LOCKED and locked source v is low, idle (no grant to others, no output) until it resumes.
REQ-016 SHALL ignore leaf_code of non-first words within a packet for length purposes; words pass through unmodified.
REQ-017 SHALL, with no v on any source in IDLE, leave rr_ptr unchanged and all a low.
REQ-018 SHALL support simultaneous drain of the output register and acceptance of a new word in the same cycle without bubble.

Reset
REQ-019 SHALL on reset: words_out.v=0, words_out.leaf_code=0, words_out.payload=0, all words_in[i].a=0, state=IDLE, remaining=0, rr_ptr=NUM_SRC-1 (so source 0 is searched first).
REQ-020 SHALL on reset mid-packet discard the lock and any buffered word; no partial packet is completed afterwards.

Configuration
REQ-021 SHALL, when macro BD_FUNNEL_ARB_PRIO0_EN is defined, in IDLE grant source 0 whenever its v is high, otherwise fall back to round-robin over sources 1..NUM_SRC-1; LOCKED packets are never preempted.
REQ-022 SHALL, without BD_FUNNEL_ARB_PRIO0_EN, treat source 0 identically to other sources under round-robin.

Structure
REQ-023 SHALL place the LEAF_WORDS[32] table (2-bit encoded length-1, entries 1..4) and leaf_code/payload width constants (5, 21) in the shared BD package alongside UnencodedBDWordChannel definitions.
REQ-024 SHALL implement the round-robin search as one sub-module RoundRobinPicker (request vector + pointer in, one-hot grant + index out, purely combinational); FSM, counter and output register live in BDFunnelArbiter.

Verification
REQ-025 Single source: src0 sends leaf with LEAF_WORDS=1, payload 21'h1ABCD, sink always ready -> words_out carries {leaf,21'h1ABCD} one cycle after accept, v high exactly one cycle.
REQ-026 Round-robin: all 4 sources continuously valid with 1-word leaves, sink ready -> output source order 0,1,2,3,0,1,... at 1 word/cycle, no bubbles after first.
REQ-027 Packet lock: src1 sends 3-word packet (LEAF_WORDS=3) while src2 is valid, src1 drops v for 2 cycles after word 1 -> no src2 words appear until src1 word 3 is output; then src2 granted.
REQ-028 Backpressure: sink a low for 5 cycles with a word buffered -> words_out data stable, v held high, all words_in a low; resumes with no loss or duplication.
REQ-029 Reset mid-packet: reset asserted after word 2 of a 4-word packet from src3 -> next cycle v=0, state IDLE; after reset src0 is granted first when all valid.
REQ-030 With BD_FUNNEL_ARB_PRIO0_EN: src0 and src1 continuously valid, 1-word leaves -> only src0 words output; src0 raised during src1 2-word packet -> src1 packet completes first.
